// File: rtl/io_pause_arbiter_pkg.sv
// Shared types and constants for the IO pause arbiter and the CPU clock divider.
package io_pause_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_GRANT   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic [1:0] PH_X = 2'd1;
  localparam logic [1:0] PH_Y = 2'd2;
  localparam logic [1:0] PH_Z = 2'd3;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic phase_valid(input logic [1:0] ph);
    return (ph == PH_X) || (ph == PH_Y) || (ph == PH_Z);
  endfunction

endpackage

// File: rtl/io_pause_arbiter_if.sv
// Requester/divider-facing bus of the IO pause arbiter.
interface io_pause_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import io_pause_arbiter_pkg::*;

  localparam int unsigned IDW = clog2(NUM_REQ);

  logic [1:0]         i_STATE;
  logic [NUM_REQ-1:0] i_REQ;
  logic [NUM_REQ-1:0] i_DONE;
  logic               o_IOPAUSE;
  logic [NUM_REQ-1:0] o_GNT;
  logic [IDW-1:0]     o_GNT_ID;
  logic               o_BUSY;
  logic               o_TIMEOUT;
  logic [IDW-1:0]     o_TIMEOUT_ID;

  modport master (
    output i_STATE, i_REQ, i_DONE,
    input  o_IOPAUSE, o_GNT, o_GNT_ID, o_BUSY, o_TIMEOUT, o_TIMEOUT_ID
  );

  modport slave (
    input  i_STATE, i_REQ, i_DONE,
    output o_IOPAUSE, o_GNT, o_GNT_ID, o_BUSY, o_TIMEOUT, o_TIMEOUT_ID
  );

endinterface

// File: rtl/io_pause_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module io_pause_arbiter_rr_picker
  import io_pause_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] onehot_c,
  output logic [IDW-1:0]     index_c,
  output logic               valid_c
);

  always_comb begin
    int unsigned pos;
    pos      = 0;
    onehot_c = '0;
    index_c  = '0;
    valid_c  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!valid_c && req_i[IDW'(pos)]) begin
        valid_c                = 1'b1;
        onehot_c[IDW'(pos)]    = 1'b1;
        index_c                = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/io_pause_arbiter.sv
// Freezes the CPU phase sequencer for one round-robin-selected IO owner at a time,
// admitting owners only at phase X and force-releasing stalled grants.
module io_pause_arbiter
  import io_pause_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic              i_CLOCK,
  input logic              i_RESET_N,
  io_pause_arbiter_if.slave bus
);

  localparam int unsigned IDW = clog2(NUM_REQ);
  localparam int unsigned SW  = (clog2(SETTLE_CYCLES + 1) < 1) ? 1 : clog2(SETTLE_CYCLES + 1);
  localparam int unsigned WW  = (clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST = (SETTLE_CYCLES == 0) ? '0 : SW'(SETTLE_CYCLES - 1);
  localparam logic [WW-1:0] WDOG_MAX    = WW'(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     gnt_id_q, gnt_id_d;
  logic [NUM_REQ-1:0] owner_oh_q, owner_oh_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [WW-1:0]      wdog_q, wdog_d;
  logic               iopause_q, iopause_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [IDW-1:0]     timeout_id_q, timeout_id_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDW-1:0]     pick_idx;
  logic               pick_valid;
  logic [WW-1:0]      wdog_inc;

  io_pause_arbiter_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_i    (bus.i_REQ),
    .ptr_i    (ptr_q),
    .onehot_c (pick_oh),
    .index_c  (pick_idx),
    .valid_c  (pick_valid)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_id_d     = gnt_id_q;
    owner_oh_d   = owner_oh_q;
    settle_d     = settle_q;
    wdog_d       = wdog_q;
    timeout_d    = timeout_q;
    timeout_id_d = timeout_id_q;
    wdog_inc     = (wdog_q == WDOG_MAX) ? wdog_q : wdog_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid && (bus.i_STATE == PH_X)) begin
          state_d    = ST_FREEZE;
          gnt_id_d   = pick_idx;
          owner_oh_d = pick_oh;
          ptr_d      = (pick_idx == IDW'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
          settle_d   = '0;
        end
      end
      ST_FREEZE: begin
        if (!(|(bus.i_REQ & owner_oh_q))) begin
          state_d = ST_RELEASE;
        end else if (settle_q >= SETTLE_LAST) begin
          state_d = ST_GRANT;
          wdog_d  = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      ST_GRANT: begin
        // A completing owner beats a watchdog expiry in the same clock.
        if (|(bus.i_DONE & owner_oh_q)) begin
          state_d = ST_RELEASE;
        end else begin
          wdog_d = wdog_inc;
          if (wdog_inc == WDOG_MAX) begin
            state_d      = ST_RELEASE;
            timeout_d    = 1'b1;
            timeout_id_d = gnt_id_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    iopause_d = (state_d == ST_FREEZE) || (state_d == ST_GRANT);
    gnt_d     = (state_d == ST_GRANT) ? owner_oh_d : '0;
    busy_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_CLOCK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gnt_id_q     <= '0;
      owner_oh_q   <= '0;
      settle_q     <= '0;
      wdog_q       <= '0;
      iopause_q    <= 1'b0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_id_q     <= gnt_id_d;
      owner_oh_q   <= owner_oh_d;
      settle_q     <= settle_d;
      wdog_q       <= wdog_d;
      iopause_q    <= iopause_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign bus.o_IOPAUSE    = iopause_q;
  assign bus.o_GNT        = gnt_q;
  assign bus.o_GNT_ID     = gnt_id_q;
  assign bus.o_BUSY       = busy_q;
  assign bus.o_TIMEOUT    = timeout_q;
  assign bus.o_TIMEOUT_ID = timeout_id_q;

endmodule
